// File: rtl/block_sf_stereo_param.sv
// Stereo sum/difference scaler: forms L+R and L-R, applies per-path gains, rounds and saturates.
// Three-stage pipeline with a valid/ack handshake that stalls every stage together.
module block_sf_stereo_param #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned KW    = 4,
    parameter int unsigned FRAC  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] LEFT,
    input  logic signed [WIDTH-1:0] RIGHT,
    input  logic        [KW-1:0]    Ks,
    input  logic        [KW-1:0]    Kd,
    input  logic                    mono,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    out_ack,
    output logic signed [WIDTH-1:0] LI_in_LpR,
    output logic signed [WIDTH-1:0] LI_in_LmR,
    output logic                    ready_out_LpR,
    output logic                    ready_out_LmR,
    output logic                    sat_flag
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned PW = WIDTH + KW + 2;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int unsigned RW = PW + 1;

    localparam logic signed [RW-1:0] Half   = RW'(1) << (FRAC - 1);
    localparam logic signed [RW-1:0] OutMax = {{(RW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [RW-1:0] OutMin = {{(RW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    logic                    v1_q, v2_q, v3_q;
    logic signed [SW-1:0]    s_q, d_q, s_d, d_d;
    logic        [KW-1:0]    ks_q, kd_q;
    logic signed [PW-1:0]    p_q, q_q, p_d, q_d;
    logic signed [WIDTH-1:0] lpr_q, lmr_q, lpr_d, lmr_d;
    logic                    sat_q;
    logic                    sat_lp, sat_lm;
    logic                    adv;
    logic signed [RW-1:0]    rp, rq;

    always_comb begin
        adv = !v3_q || out_ack;

        s_d = SW'(LEFT) + SW'(RIGHT);
        d_d = mono ? '0 : SW'(LEFT) - SW'(RIGHT);

        p_d = PW'(s_q) * $signed(PW'(ks_q));
        q_d = PW'(d_q) * $signed(PW'(kd_q));

        rp = (RW'(p_q) + Half) >>> FRAC;
        rq = (RW'(q_q) + Half) >>> FRAC;

        sat_lp = 1'b0;
        sat_lm = 1'b0;
        lpr_d  = rp[WIDTH-1:0];
        lmr_d  = rq[WIDTH-1:0];
        if (rp > OutMax) begin
            lpr_d  = OutMax[WIDTH-1:0];
            sat_lp = 1'b1;
        end else if (rp < OutMin) begin
            lpr_d  = OutMin[WIDTH-1:0];
            sat_lp = 1'b1;
        end
        if (rq > OutMax) begin
            lmr_d  = OutMax[WIDTH-1:0];
            sat_lm = 1'b1;
        end else if (rq < OutMin) begin
            lmr_d  = OutMin[WIDTH-1:0];
            sat_lm = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s_q   <= '0;
            d_q   <= '0;
            ks_q  <= '0;
            kd_q  <= '0;
            p_q   <= '0;
            q_q   <= '0;
            lpr_q <= '0;
            lmr_q <= '0;
            sat_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                s_q  <= s_d;
                d_q  <= d_d;
                ks_q <= Ks;
                kd_q <= Kd;
            end
            if (v1_q) begin
                p_q <= p_d;
                q_q <= q_d;
            end
            // Bubbles leave the last result on the outputs; only real samples update them.
            if (v2_q) begin
                lpr_q <= lpr_d;
                lmr_q <= lmr_d;
                if (sat_lp || sat_lm) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready      = adv;
        LI_in_LpR     = lpr_q;
        LI_in_LmR     = lmr_q;
        ready_out_LpR = v3_q;
        ready_out_LmR = v3_q;
        sat_flag      = sat_q;
    end

endmodule

// File: tb/tb_block_sf_stereo_param.sv
// Scoreboard bench for block_sf_stereo_param: accepted samples push expected results,
// an output monitor pops and compares on every output transfer.
module tb_block_sf_stereo_param;

    localparam int W    = 18;
    localparam int KW   = 4;
    localparam int FRAC = 3;
    localparam longint MaxV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MinV = -(longint'(1) <<< (W - 1));

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic signed [W-1:0] LEFT = '0;
    logic signed [W-1:0] RIGHT = '0;
    logic [KW-1:0]       Ks = '0;
    logic [KW-1:0]       Kd = '0;
    logic                mono = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                out_ack = 1'b1;
    logic signed [W-1:0] LI_in_LpR;
    logic signed [W-1:0] LI_in_LmR;
    logic                ready_out_LpR;
    logic                ready_out_LmR;
    logic                sat_flag;

    always #5 clock = ~clock;

    block_sf_stereo_param #(.WIDTH(W), .KW(KW), .FRAC(FRAC)) dut (
        .clock        (clock),
        .reset        (reset),
        .LEFT         (LEFT),
        .RIGHT        (RIGHT),
        .Ks           (Ks),
        .Kd           (Kd),
        .mono         (mono),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_ack      (out_ack),
        .LI_in_LpR    (LI_in_LpR),
        .LI_in_LmR    (LI_in_LmR),
        .ready_out_LpR(ready_out_LpR),
        .ready_out_LmR(ready_out_LmR),
        .sat_flag     (sat_flag)
    );

    typedef struct {
        longint lpr;
        longint lmr;
        bit     sat;
    } exp_t;

    exp_t exp_q[$];
    bit   model_sat = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: real-valued gain with round-half-up, then clamp to the output range.
    function automatic longint scale(input longint x, input longint k);
        return (x * k + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    endfunction

    function automatic longint clampv(input longint v);
        if (v > MaxV) return MaxV;
        if (v < MinV) return MinV;
        return v;
    endfunction

    always @(negedge clock) begin
        exp_t   e;
        longint s, d, a, b;
        if (reset && in_valid && in_ready) begin
            s = longint'(LEFT) + longint'(RIGHT);
            d = mono ? 0 : longint'(LEFT) - longint'(RIGHT);
            a = scale(s, longint'(Ks));
            b = scale(d, longint'(Kd));
            if (a != clampv(a) || b != clampv(b)) model_sat = 1'b1;
            e.lpr = clampv(a);
            e.lmr = clampv(b);
            e.sat = model_sat;
            exp_q.push_back(e);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset && ready_out_LpR && out_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("LpR", 64'(LI_in_LpR), e.lpr);
                check("LmR", 64'(LI_in_LmR), e.lmr);
                check("sat_flag", 64'(sat_flag), 64'(e.sat));
                check("ready_LmR", 64'(ready_out_LmR), 64'(1));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the sample was accepted.
    task automatic send(input int l, input int r, input int ks, input int kd, input bit m);
        int n;
        bit acc;
        LEFT     = W'(l);
        RIGHT    = W'(r);
        Ks       = KW'(ks);
        Kd       = KW'(kd);
        mono     = m;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Requires an empty pipeline and out_ack=1: result must show up on exactly the third edge.
    task automatic send_lat(input int l, input int r, input int ks, input int kd);
        LEFT     = W'(l);
        RIGHT    = W'(r);
        Ks       = KW'(ks);
        Kd       = KW'(kd);
        mono     = 1'b0;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("lat_edge1", 64'(ready_out_LpR), 64'(0));
        @(posedge clock);
        #1;
        check("lat_edge2", 64'(ready_out_LpR), 64'(0));
        @(posedge clock);
        #1;
        check("lat_edge3", 64'(ready_out_LpR), 64'(1));
    endtask

    initial begin
        logic signed [W-1:0] hold;
        bit rand_on;
        int n;

        #12;
        check("rst_ready_out", 64'(ready_out_LpR), 64'(0));
        check("rst_LpR", 64'(LI_in_LpR), 64'(0));
        check("rst_LmR", 64'(LI_in_LmR), 64'(0));
        check("rst_sat", 64'(sat_flag), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clock);
        #1;

        // T1: basic rounding, LmR = -25.5 rounds up to -25
        send_lat(15, 32, 8, 12);
        idle(4);

        // T2: saturation both directions, sticky flag
        send(131071, 131071, 15, 0, 1'b0);
        send(-131072, -131072, 15, 0, 1'b0);
        idle(5);
        check("sat_sticky", 64'(sat_flag), 64'(1));

        // T3: mono then stereo
        send(100, -50, 8, 15, 1'b1);
        send(100, -50, 8, 15, 1'b0);
        idle(5);

        // T4: 8-sample stream with a 4-cycle stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(10 + 5 * i, 20 - 7 * i, 8, 8, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) begin
                    @(posedge clock);
                    #1;
                end
                out_ack = 1'b0;
                hold = LI_in_LpR;
                repeat (4) begin
                    @(negedge clock);
                    check("stall_in_ready", 64'(in_ready), 64'(0));
                    check("stall_ready_out", 64'(ready_out_LpR), 64'(1));
                    check("stall_hold", 64'(LI_in_LpR), 64'(hold));
                    @(posedge clock);
                    #1;
                end
                out_ack = 1'b1;
            end
        join
        idle(6);

        // T5: gain change on back-to-back accepts
        send(40, 8, 8, 8, 1'b0);
        send(40, 8, 4, 8, 1'b0);
        idle(5);

        // T6: reset with samples in flight and an output pending
        out_ack = 1'b0;
        send(1, 2, 8, 8, 1'b0);
        send(3, 4, 8, 8, 1'b0);
        send(5, 6, 8, 8, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_ready_out", 64'(ready_out_LpR), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        model_sat = 1'b0;
        check("midrst_ready_LpR", 64'(ready_out_LpR), 64'(0));
        check("midrst_ready_LmR", 64'(ready_out_LmR), 64'(0));
        check("midrst_LpR", 64'(LI_in_LpR), 64'(0));
        check("midrst_LmR", 64'(LI_in_LmR), 64'(0));
        check("midrst_sat", 64'(sat_flag), 64'(0));
        @(posedge clock);
        #1;
        reset   = 1'b1;
        out_ack = 1'b1;
        @(posedge clock);
        #1;
        send_lat(7, 9, 8, 8);
        idle(4);

        // Random traffic with random backpressure
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int l, r;
                    if ($urandom % 4 == 0) idle(1 + int'($urandom % 2));
                    l = int'($urandom_range(0, 262143)) - 131072;
                    r = int'($urandom_range(0, 262143)) - 131072;
                    if ($urandom % 8 == 0) l = ($urandom % 2 == 0) ? 131071 : -131072;
                    if ($urandom % 8 == 0) r = ($urandom % 2 == 0) ? 131071 : -131072;
                    send(l, r, int'($urandom % 16), int'($urandom % 16), ($urandom % 8) == 0);
                end
                in_valid = 1'b0;
                rand_on  = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clock);
                    #1;
                    out_ack = ($urandom % 4) != 0;
                end
            end
        join

        out_ack = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
